aclk_controller: RTL and testbench

- Key-entry sequencer for the alarm clock. Decodes the keypad and shifts digits into a 4-digit entry buffer.
- Drives the load strobes of the time counter (load_new_c) and the alarm register (load_new_a), plus the display select lines.
- Sits between the keypad scanner and the counter/alarm register/display mux. Its buffer outputs feed the counter's new-time inputs directly.

---
 rtl/aclk_controller.sv | 154 +++++++++++++++
 tb/tb_aclk_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/aclk_controller.sv
// Alarm-clock key-entry sequencer: decodes keypad codes into a 4-digit entry buffer and
// drives the counter/alarm load strobes and display selects. Optional ACLK_CTRL_TIME_CHECK_EN adds an err output.
module aclk_controller #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  output logic [3:0] new_time_ms_hr,
  output logic [3:0] new_time_ls_hr,
  output logic [3:0] new_time_ms_min,
  output logic [3:0] new_time_ls_min,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       show_a,
  output logic       show_new_time
`ifdef ACLK_CTRL_TIME_CHECK_EN
  ,
  output logic       err
`endif
);

  localparam logic [2:0] SHOW_TIME   = 3'd0;
  localparam logic [2:0] KEY_STORED  = 3'd1;
  localparam logic [2:0] KEY_WAITED  = 3'd2;
  localparam logic [2:0] KEY_ENTERED = 3'd3;
  localparam logic [2:0] LOAD_WAIT   = 3'd4;
  localparam logic [2:0] SHOW_ALARM  = 3'd5;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_SEC - 1);

  logic [1:0]  rst_sync;
  logic        rst_n;
  logic [2:0]  state, next_state;
  logic [15:0] digits, next_digits;
  logic [7:0]  count, next_count, count_inc;
  logic        next_load_c, next_load_a;
  logic        is_digit, is_none, is_alarm, is_time, timeout;

  // Assertion reaches the state flops immediately; release is aligned to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign is_digit  = (key <= 4'd9);
  assign is_alarm  = (key == 4'hA);
  assign is_time   = (key == 4'hB);
  assign is_none   = (key >= 4'hC);
  assign timeout   = one_second && (count == LAST_COUNT);
  assign count_inc = (one_second && count != 8'hFF) ? count + 8'd1 : count;

`ifdef ACLK_CTRL_TIME_CHECK_EN
  logic next_err, buffer_ok;
  assign buffer_ok = (digits[15:12] <= 4'd2)
                  && (digits[15:12] != 4'd2 || digits[11:8] <= 4'd3)
                  && (digits[11:8] <= 4'd9)
                  && (digits[7:4] <= 4'd5)
                  && (digits[3:0] <= 4'd9);
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    next_state  = state;
    next_digits = digits;
    next_count  = count;
    next_load_c = 1'b0;
    next_load_a = 1'b0;
`ifdef ACLK_CTRL_TIME_CHECK_EN
    next_err    = 1'b0;
`endif
    case (state)
      SHOW_TIME: begin
        if (is_alarm) begin
          next_state = SHOW_ALARM;
        end else if (is_digit) begin
          next_state  = KEY_STORED;
          next_digits = {12'h000, key};
        end
      end
      KEY_STORED: begin
        next_state = KEY_WAITED;
        next_count = 8'd0;
      end
      KEY_WAITED: begin
        next_count = count_inc;
        if (timeout)      next_state = SHOW_TIME;
        else if (is_none) next_state = KEY_ENTERED;
      end
      KEY_ENTERED: begin
        next_count = count_inc;
        if (is_digit) begin
          next_state  = KEY_STORED;
          next_digits = {digits[11:0], key};
        end else if (is_time || is_alarm) begin
          next_state = LOAD_WAIT;
`ifdef ACLK_CTRL_TIME_CHECK_EN
          if (!buffer_ok) begin
            next_err = 1'b1;
          end else begin
            next_load_c = is_time;
            next_load_a = is_alarm;
          end
`else
          next_load_c = is_time;
          next_load_a = is_alarm;
`endif
        end else if (timeout) begin
          next_state = SHOW_TIME;
        end
      end
      LOAD_WAIT:  if (is_none) next_state = SHOW_TIME;
      SHOW_ALARM: if (is_none) next_state = SHOW_TIME;
      default:    next_state = SHOW_TIME;
    endcase
  end

  // Selects are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SHOW_TIME;
      digits        <= 16'h0000;
      count         <= 8'd0;
      load_new_c    <= 1'b0;
      load_new_a    <= 1'b0;
      show_a        <= 1'b0;
      show_new_time <= 1'b0;
    end else begin
      state         <= next_state;
      digits        <= next_digits;
      count         <= next_count;
      load_new_c    <= next_load_c;
      load_new_a    <= next_load_a;
      show_a        <= (next_state == SHOW_ALARM);
      show_new_time <= (next_state == KEY_STORED) || (next_state == KEY_WAITED)
                    || (next_state == KEY_ENTERED) || (next_state == LOAD_WAIT);
    end
  end

`ifdef ACLK_CTRL_TIME_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= next_err;
  end
`endif

  assign new_time_ms_hr  = digits[15:12];
  assign new_time_ls_hr  = digits[11:8];
  assign new_time_ms_min = digits[7:4];
  assign new_time_ls_min = digits[3:0];

endmodule

// File: tb/tb_aclk_controller.sv
// Bench for aclk_controller: directed scenarios plus randomized key/tick streams,
// compared every cycle against a behavioural model of the entry sequence.
module tb_aclk_controller;

  localparam int TO = 10;
`ifdef ACLK_CTRL_TIME_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       one_second = 1'b0;
  logic [3:0] key = 4'hF;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       load_new_c, load_new_a, show_a, show_new_time;
  logic       err_o;

  aclk_controller #(.TIMEOUT_SEC(TO)) dut (
    .clk(clk), .reset(reset), .one_second(one_second), .key(key),
    .new_time_ms_hr(ms_hr), .new_time_ls_hr(ls_hr),
    .new_time_ms_min(ms_min), .new_time_ls_min(ls_min),
    .load_new_c(load_new_c), .load_new_a(load_new_a),
    .show_a(show_a), .show_new_time(show_new_time)
`ifdef ACLK_CTRL_TIME_CHECK_EN
    , .err(err_o)
`endif
  );
`ifndef ACLK_CTRL_TIME_CHECK_EN
  assign err_o = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: user-level modes, digit queue, seconds idle.
  typedef enum {M_IDLE, M_ALARM, M_JUST, M_HELD, M_FREE, M_LOCK} mode_t;
  mode_t m = M_IDLE;
  int    dq[$];
  int    secs = 0;
  bit    m_lc, m_la, m_er;

  function automatic logic [15:0] buf_val();
    logic [15:0] v = 16'h0;
    foreach (dq[i]) v = {v[11:0], 4'(dq[i])};
    return v;
  endfunction

  function automatic bit entry_valid();
    logic [15:0] v = buf_val();
    int hours = int'(v[15:12]) * 10 + int'(v[11:8]);
    return (hours <= 23) && (v[7:4] <= 4'd5) && (v[11:8] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  task automatic model_reset();
    m = M_IDLE; dq.delete(); secs = 0; m_lc = 0; m_la = 0; m_er = 0;
  endtask

  task automatic model_step(input logic [3:0] k, input bit t);
    bit dig  = (k <= 4'd9);
    bit none = (k >= 4'hC);
    bit tmo  = t && (secs == TO - 1);
    m_lc = 0; m_la = 0; m_er = 0;
    case (m)
      M_IDLE:  if (k == 4'hA) m = M_ALARM;
               else if (dig) begin dq.delete(); dq.push_back(int'(k)); m = M_JUST; end
      M_ALARM: if (none) m = M_IDLE;
      M_LOCK:  if (none) m = M_IDLE;
      M_JUST:  begin secs = 0; m = M_HELD; end
      M_HELD: begin
        if (tmo) m = M_IDLE;
        else if (none) m = M_FREE;
        if (t && secs < 255) secs++;
      end
      M_FREE: begin
        if (dig) begin
          dq.push_back(int'(k));
          if (dq.size() > 4) void'(dq.pop_front());
          m = M_JUST;
        end else if (k == 4'hA || k == 4'hB) begin
          if (CHK && !entry_valid()) m_er = 1;
          else if (k == 4'hB) m_lc = 1;
          else m_la = 1;
          m = M_LOCK;
        end else if (tmo) m = M_IDLE;
        if (t && secs < 255) secs++;
      end
      default: m = M_IDLE;
    endcase
  endtask

  task automatic compare(input string tag);
    check({tag, ".buf"}, {16'h0, ms_hr, ls_hr, ms_min, ls_min}, {16'h0, buf_val()});
    check({tag, ".strb"}, {30'h0, load_new_c, load_new_a}, {30'h0, m_lc, m_la});
    check({tag, ".sel"}, {30'h0, show_a, show_new_time},
          {30'h0, m == M_ALARM, m inside {M_JUST, M_HELD, M_FREE, M_LOCK}});
    if (CHK) check({tag, ".err"}, {31'h0, err_o}, {31'h0, m_er});
  endtask

  task automatic cycle(input string tag, input logic [3:0] k, input bit t);
    key = k; one_second = t;
    @(posedge clk); #1;
    model_step(k, t);
    compare(tag);
  endtask

  task automatic press(input string tag, input logic [3:0] d);
    cycle(tag, d, 0); cycle(tag, 4'hF, 0); cycle(tag, 4'hF, 0);
  endtask

  initial begin
    int pulses;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset.outs", {20'h0, ms_hr, ls_hr, ms_min, ls_min, load_new_c, load_new_a, show_a, show_new_time}, 32'h0);
    @(negedge clk); reset = 1'b1;
    repeat (3) cycle("idle", 4'hF, 0);

    // Entry 1,2,3,4 then TIME held.
    press("t1", 4'd1); press("t1", 4'd2); press("t1", 4'd3); press("t1", 4'd4);
    pulses = 0;
    cycle("t1.time", 4'hB, 0);
    check("t1.lc", {31'h0, load_new_c}, 32'd1);
    check("t1.buf", {16'h0, ms_hr, ls_hr, ms_min, ls_min}, 32'h1234);
    for (int i = 0; i < 5; i++) begin
      cycle("t1.hold", 4'hB, 0);
      pulses += int'(load_new_c) + int'(load_new_a);
      check("t1.show_a", {31'h0, show_a}, 32'd0);
    end
    check("t1.extra_strobes", pulses, 0);
    cycle("t1.rel", 4'hF, 0);

    // ALARM view held.
    for (int i = 0; i < 3; i++) begin
      cycle("t2.alarm", 4'hA, 0);
      check("t2.show_a", {31'h0, show_a}, 32'd1);
    end
    cycle("t2.rel", 4'hF, 0);
    check("t2.show_a_off", {31'h0, show_a}, 32'd0);

    // Timeout after TO ticks, then a digit on the last tick.
    cycle("t3", 4'd5, 0); cycle("t3", 4'hF, 0);
    for (int i = 0; i < TO; i++) cycle("t3.tick", 4'hF, 1);
    check("t3.timed_out", {31'h0, show_new_time}, 32'd0);
    cycle("t4", 4'd5, 0); cycle("t4", 4'hF, 0);
    for (int i = 0; i < TO - 1; i++) cycle("t4.tick", 4'hF, 1);
    cycle("t4.dig", 4'd7, 1);
    check("t4.stored", {31'h0, show_new_time}, 32'd1);
    check("t4.buf", {16'h0, ms_hr, ls_hr, ms_min, ls_min}, 32'h0057);
    cycle("t4", 4'hF, 0);
    for (int i = 0; i < TO; i++) cycle("t4.tick", 4'hF, 1);

    // Five digits then ALARM.
    for (int d = 1; d <= 5; d++) press("t5", 4'(d));
    cycle("t5.alarm", 4'hA, 0);
    check("t5.la", {30'h0, load_new_c, load_new_a}, 32'd1);
    check("t5.buf", {16'h0, ms_hr, ls_hr, ms_min, ls_min}, 32'h2345);
    cycle("t5.rel", 4'hF, 0);

`ifdef ACLK_CTRL_TIME_CHECK_EN
    press("t6", 4'd2); press("t6", 4'd5); press("t6", 4'd0); press("t6", 4'd0);
    cycle("t6.time", 4'hB, 0);
    check("t6.err", {30'h0, err_o, load_new_c}, 32'd2);
    cycle("t6.rel", 4'hF, 0);
    press("t6", 4'd2); press("t6", 4'd3); press("t6", 4'd5); press("t6", 4'd9);
    cycle("t6.time", 4'hB, 0);
    check("t6.ok", {30'h0, err_o, load_new_c}, 32'd1);
    cycle("t6.rel", 4'hF, 0);
`endif

    // Reset mid-entry (KEY_WAITED, buffer 0012).
    cycle("t7", 4'd1, 0); cycle("t7", 4'hF, 0); cycle("t7", 4'hF, 0);
    cycle("t7", 4'd2, 0); cycle("t7", 4'd2, 0);
    #2 reset = 1'b0;
    #1;
    check("t7.rst", {20'h0, ms_hr, ls_hr, ms_min, ls_min, load_new_c, load_new_a, show_a, show_new_time}, 32'h0);
    model_reset();
    #3 reset = 1'b1;
    repeat (3) cycle("t7.idle", 4'hF, 0);
    cycle("t7.alarm", 4'hA, 0);
    check("t7.show_a", {31'h0, show_a}, 32'd1);
    cycle("t7.rel", 4'hF, 0);

    // Randomized key streams.
    for (int it = 0; it < 1500; it++) begin
      int r = int'($urandom_range(0, 19));
      int hold = int'($urandom_range(1, 4));
      int gap = int'($urandom_range(0, 8));
      logic [3:0] k;
      if (r < 12)      k = 4'($urandom_range(0, 9));
      else if (r < 14) k = 4'hA;
      else if (r < 16) k = 4'hB;
      else if (r < 17) k = 4'($urandom_range(12, 14));
      else             k = 4'hF;
      for (int h = 0; h < hold; h++) cycle("rnd", k, $urandom_range(0, 2) == 0);
      for (int g = 0; g < gap; g++) cycle("rnd", 4'hF, $urandom_range(0, 1) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
